// File: rtl/mips_multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl_if
// Bundles the signals between the multicycle control FSM and the MIPS-lite
// datapath / memories.
//   Datapath -> control : opcode, funct, zero, imem_ready, dmem_ready
//   Control -> datapath : SIG_PC_W, SIG_IR_W, SIG_RF_W, SIG_DM_W, SIG_DM_R,
//                         SIG_REG_DST, SIG_MEM_TO_REG, SIG_ALU_SRC,
//                         SIG_ALU_OP, SIG_EXT_OP, SIG_NPC_SEL
// modport master : the control FSM (drives the strobes and selects)
// modport slave  : the datapath side (drives instruction fields and readies)
// ---------------------------------------------------------------------------
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       imem_ready;
  logic       dmem_ready;

  logic       SIG_PC_W;
  logic       SIG_IR_W;
  logic       SIG_RF_W;
  logic       SIG_DM_W;
  logic       SIG_DM_R;
  logic [1:0] SIG_REG_DST;
  logic [1:0] SIG_MEM_TO_REG;
  logic       SIG_ALU_SRC;
  logic [2:0] SIG_ALU_OP;
  logic [1:0] SIG_EXT_OP;
  logic [1:0] SIG_NPC_SEL;

  modport master (
    input  opcode, funct, zero, imem_ready, dmem_ready,
    output SIG_PC_W, SIG_IR_W, SIG_RF_W, SIG_DM_W, SIG_DM_R,
           SIG_REG_DST, SIG_MEM_TO_REG, SIG_ALU_SRC, SIG_ALU_OP,
           SIG_EXT_OP, SIG_NPC_SEL
  );

  modport slave (
    output opcode, funct, zero, imem_ready, dmem_ready,
    input  SIG_PC_W, SIG_IR_W, SIG_RF_W, SIG_DM_W, SIG_DM_R,
           SIG_REG_DST, SIG_MEM_TO_REG, SIG_ALU_SRC, SIG_ALU_OP,
           SIG_EXT_OP, SIG_NPC_SEL
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
// Multicycle control FSM for the MIPS-lite datapath. Sequences
// FETCH -> DECODE -> EXEC -> MEM -> WB, drives the datapath write strobes and
// mux selects, waits on instruction/data memory ready, and counts retired
// legal instructions.
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   bus      : control/datapath signal bundle (master side)
//   illegal  : one-cycle pulse in DECODE on an undecodable instruction
//   state    : current FSM state (FETCH 000 .. WB 100)
//   retired  : count of completed legal instructions, wraps
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  mips_multicycle_ctrl_if.master    bus,
  output logic                      illegal,
  output logic [2:0]                state,
  output logic [CNT_W-1:0]          retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'b000,
    DECODE = 3'b001,
    EXEC   = 3'b010,
    MEM    = 3'b011,
    WB     = 3'b100
  } state_t;

  state_t cur_state;
  state_t next_state;
  logic   retire;

  // Instruction decode from the IR fields
  logic is_addu, is_subu, is_rtype, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_j, is_jal, is_legal;

  assign is_addu  = (bus.opcode == 6'b000000) && (bus.funct == 6'b100001);
  assign is_subu  = (bus.opcode == 6'b000000) && (bus.funct == 6'b100011);
  assign is_rtype = is_addu || is_subu;
  assign is_ori   = (bus.opcode == 6'b001101);
  assign is_lui   = (bus.opcode == 6'b001111);
  assign is_lw    = (bus.opcode == 6'b100011);
  assign is_sw    = (bus.opcode == 6'b101011);
  assign is_beq   = (bus.opcode == 6'b000100);
  assign is_j     = (bus.opcode == 6'b000010);
  assign is_jal   = (bus.opcode == 6'b000011);
  assign is_legal = is_rtype || is_ori || is_lui || is_lw || is_sw ||
                    is_beq || is_j || is_jal;

  // ALU operand configuration chosen in EXEC; it is held through MEM and WB
  // so the datapath keeps computing the same address/result.
  logic       alu_src_x;
  logic [2:0] alu_op_x;
  logic [1:0] ext_op_x;

  always_comb begin
    alu_src_x = 1'b0;
    alu_op_x  = 3'b000;
    ext_op_x  = 2'b00;
    if (is_subu) begin
      alu_op_x = 3'b001;
    end else if (is_ori) begin
      alu_src_x = 1'b1;
      alu_op_x  = 3'b010;
      ext_op_x  = 2'b00;
    end else if (is_lui) begin
      alu_src_x = 1'b1;
      alu_op_x  = 3'b011;
      ext_op_x  = 2'b10;
    end else if (is_lw || is_sw) begin
      alu_src_x = 1'b1;
      alu_op_x  = 3'b000;
      ext_op_x  = 2'b01;
    end else if (is_beq) begin
      alu_op_x  = 3'b001;
      ext_op_x  = 2'b01;
    end
  end

  // Next-state and output decode. Reset overrides every strobe and select
  // combinationally so a store in flight is dropped in the same cycle.
  logic       pc_w, ir_w, rf_w, dm_w, dm_r, ill;
  logic [1:0] reg_dst, mem_to_reg, ext_op, npc_sel;
  logic       alu_src;
  logic [2:0] alu_op;

  always_comb begin
    next_state = FETCH;
    retire     = 1'b0;
    pc_w       = 1'b0;
    ir_w       = 1'b0;
    rf_w       = 1'b0;
    dm_w       = 1'b0;
    dm_r       = 1'b0;
    ill        = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src    = 1'b0;
    alu_op     = 3'b000;
    ext_op     = 2'b00;
    npc_sel    = 2'b00;

    case (cur_state)
      FETCH: begin
        if (bus.imem_ready) begin
          ir_w       = 1'b1;
          pc_w       = 1'b1;
          next_state = DECODE;
        end else begin
          next_state = FETCH;
        end
      end

      DECODE: begin
        if (is_j || is_jal) begin
          pc_w    = 1'b1;
          npc_sel = 2'b10;
          retire  = 1'b1;
          if (is_jal) begin
            rf_w       = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end
          next_state = FETCH;
        end else if (!is_legal) begin
          // PC was already advanced in FETCH, so just drop the instruction
          ill        = 1'b1;
          next_state = FETCH;
        end else begin
          next_state = EXEC;
        end
      end

      EXEC: begin
        alu_src = alu_src_x;
        alu_op  = alu_op_x;
        ext_op  = ext_op_x;
        if (is_beq) begin
          npc_sel    = 2'b01;
          pc_w       = bus.zero;
          retire     = 1'b1;
          next_state = FETCH;
        end else if (is_lw || is_sw) begin
          next_state = MEM;
        end else if (is_legal) begin
          next_state = WB;
        end else begin
          next_state = FETCH;
        end
      end

      MEM: begin
        alu_src = alu_src_x;
        alu_op  = alu_op_x;
        ext_op  = ext_op_x;
        if (is_lw) begin
          dm_r       = 1'b1;
          next_state = bus.dmem_ready ? WB : MEM;
        end else if (is_sw) begin
          dm_w = 1'b1;
          if (bus.dmem_ready) begin
            retire     = 1'b1;
            next_state = FETCH;
          end else begin
            next_state = MEM;
          end
        end else begin
          next_state = FETCH;
        end
      end

      WB: begin
        alu_src    = alu_src_x;
        alu_op     = alu_op_x;
        ext_op     = ext_op_x;
        rf_w       = 1'b1;
        reg_dst    = is_rtype ? 2'b01 : 2'b00;
        mem_to_reg = is_lw ? 2'b01 : 2'b00;
        retire     = 1'b1;
        next_state = FETCH;
      end

      default: begin
        next_state = FETCH;
      end
    endcase

    if (rst) begin
      retire     = 1'b0;
      pc_w       = 1'b0;
      ir_w       = 1'b0;
      rf_w       = 1'b0;
      dm_w       = 1'b0;
      dm_r       = 1'b0;
      ill        = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      alu_src    = 1'b0;
      alu_op     = 3'b000;
      ext_op     = 2'b00;
      npc_sel    = 2'b00;
    end
  end

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= FETCH;
      retired   <= '0;
    end else begin
      cur_state <= next_state;
      if (retire) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

  assign state              = cur_state;
  assign illegal            = ill;
  assign bus.SIG_PC_W       = pc_w;
  assign bus.SIG_IR_W       = ir_w;
  assign bus.SIG_RF_W       = rf_w;
  assign bus.SIG_DM_W       = dm_w;
  assign bus.SIG_DM_R       = dm_r;
  assign bus.SIG_REG_DST    = reg_dst;
  assign bus.SIG_MEM_TO_REG = mem_to_reg;
  assign bus.SIG_ALU_SRC    = alu_src;
  assign bus.SIG_ALU_OP     = alu_op;
  assign bus.SIG_EXT_OP     = ext_op;
  assign bus.SIG_NPC_SEL    = npc_sel;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Drives instructions through the control FSM and compares every cycle
// against a per-instruction phase list built from the instruction's class.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic        illegal;
  logic [2:0]  state;
  logic [31:0] retired;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.master),
    .illegal (illegal),
    .state   (state),
    .retired (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of every strobe and select:
  // {PC_W, IR_W, RF_W, DM_W, DM_R, illegal, REG_DST, MEM_TO_REG,
  //  ALU_SRC, ALU_OP, EXT_OP, NPC_SEL}
  logic [17:0] ctl_obs;
  assign ctl_obs = {bus.SIG_PC_W, bus.SIG_IR_W, bus.SIG_RF_W, bus.SIG_DM_W,
                    bus.SIG_DM_R, illegal, bus.SIG_REG_DST, bus.SIG_MEM_TO_REG,
                    bus.SIG_ALU_SRC, bus.SIG_ALU_OP, bus.SIG_EXT_OP,
                    bus.SIG_NPC_SEL};

  typedef struct {
    logic [2:0]  st;
    logic [17:0] ctl;
    logic        imem;
    logic        dmem;
    logic        zero;
  } cyc_t;

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4,
                 K_SW = 5, K_BEQ = 6, K_J = 7, K_JAL = 8, K_ILL = 9;

  int          n_cmp;
  int          n_err;
  logic [31:0] exp_ret;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_cmp++;
    if (observed !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:   kind_of = (fn == 6'h21) ? K_ADDU : (fn == 6'h23) ? K_SUBU : K_ILL;
      6'h0D:   kind_of = K_ORI;
      6'h0F:   kind_of = K_LUI;
      6'h23:   kind_of = K_LW;
      6'h2B:   kind_of = K_SW;
      6'h04:   kind_of = K_BEQ;
      6'h02:   kind_of = K_J;
      6'h03:   kind_of = K_JAL;
      default: kind_of = K_ILL;
    endcase
  endfunction

  function automatic logic [17:0] mk(
    input logic pc_w, input logic ir_w, input logic rf_w, input logic dm_w,
    input logic dm_r, input logic ill, input logic [1:0] rdst,
    input logic [1:0] m2r, input logic asrc, input logic [2:0] aop,
    input logic [1:0] ext, input logic [1:0] npc);
    mk = {pc_w, ir_w, rf_w, dm_w, dm_r, ill, rdst, m2r, asrc, aop, ext, npc};
  endfunction

  function automatic cyc_t cyc(input logic [2:0] st, input logic [17:0] ctl,
                               input logic imem, input logic dmem,
                               input logic zero);
    cyc.st   = st;
    cyc.ctl  = ctl;
    cyc.imem = imem;
    cyc.dmem = dmem;
    cyc.zero = zero;
  endfunction

  // Builds the cycle-by-cycle expectation for one instruction, drives it and
  // checks state, strobes and the retired count. rst_at >= 0 asserts reset in
  // that cycle of the instruction instead of letting it finish.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input int fstall,
                               input int mstall, input int rst_at);
    cyc_t       q[$];
    int         k;
    logic       asrc;
    logic [2:0] aop;
    logic [1:0] ext;
    logic       legal;
    logic [17:0] cfg;

    k     = kind_of(op, fn);
    legal = (k != K_ILL);
    asrc  = 1'b0;
    aop   = 3'b000;
    ext   = 2'b00;
    case (k)
      K_SUBU:     aop = 3'b001;
      K_ORI:      begin asrc = 1'b1; aop = 3'b010; ext = 2'b00; end
      K_LUI:      begin asrc = 1'b1; aop = 3'b011; ext = 2'b10; end
      K_LW, K_SW: begin asrc = 1'b1; aop = 3'b000; ext = 2'b01; end
      K_BEQ:      begin aop = 3'b001; ext = 2'b01; end
      default:    ;
    endcase
    cfg = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, asrc, aop, ext, 2'b00);

    for (int s = 0; s < fstall; s++)
      q.push_back(cyc(3'd0, 18'd0, 1'b0, 1'($urandom), 1'($urandom)));
    q.push_back(cyc(3'd0, mk(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b000, 2'b00, 2'b00),
                    1'b1, 1'($urandom), 1'($urandom)));

    if (k == K_J)
      q.push_back(cyc(3'd1, mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b000, 2'b00, 2'b10),
                      1'($urandom), 1'($urandom), 1'($urandom)));
    else if (k == K_JAL)
      q.push_back(cyc(3'd1, mk(1, 0, 1, 0, 0, 0, 2'b10, 2'b10, 0, 3'b000, 2'b00, 2'b10),
                      1'($urandom), 1'($urandom), 1'($urandom)));
    else if (k == K_ILL)
      q.push_back(cyc(3'd1, mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 3'b000, 2'b00, 2'b00),
                      1'($urandom), 1'($urandom), 1'($urandom)));
    else begin
      q.push_back(cyc(3'd1, 18'd0, 1'($urandom), 1'($urandom), 1'($urandom)));
      if (k == K_BEQ)
        q.push_back(cyc(3'd2, cfg | mk(z, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b000, 2'b00, 2'b01),
                        1'($urandom), 1'($urandom), z));
      else
        q.push_back(cyc(3'd2, cfg, 1'($urandom), 1'($urandom), 1'($urandom)));
      if (k == K_LW || k == K_SW) begin
        cfg = cfg | mk(0, 0, 0, (k == K_SW), (k == K_LW), 0, 2'b00, 2'b00, 0, 3'b000, 2'b00, 2'b00);
        for (int s = 0; s < mstall; s++)
          q.push_back(cyc(3'd3, cfg, 1'($urandom), 1'b0, 1'($urandom)));
        q.push_back(cyc(3'd3, cfg, 1'($urandom), 1'b1, 1'($urandom)));
      end
      if (k != K_BEQ && k != K_SW) begin
        cfg = mk(0, 0, 1, 0, 0, 0, (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00,
                 (k == K_LW) ? 2'b01 : 2'b00, asrc, aop, ext, 2'b00);
        q.push_back(cyc(3'd4, cfg, 1'($urandom), 1'($urandom), 1'($urandom)));
      end
    end

    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      bus.opcode     = op;
      bus.funct      = fn;
      bus.imem_ready = q[i].imem;
      bus.dmem_ready = q[i].dmem;
      bus.zero       = q[i].zero;
      rst            = (i == rst_at);
      #1;
      checkOutput("state", 32'(state), 32'(q[i].st));
      checkOutput(rst ? "ctl_in_reset" : "ctl", 32'(ctl_obs), rst ? 32'd0 : 32'(q[i].ctl));
      checkOutput("retired", retired, exp_ret);
      if (rst) begin
        @(negedge clk);
        rst            = 1'b0;
        bus.imem_ready = 1'b0;
        exp_ret        = 32'd0;
        #1;
        checkOutput("state_after_reset", 32'(state), 32'd0);
        checkOutput("ctl_after_reset", 32'(ctl_obs), 32'd0);
        checkOutput("retired_after_reset", retired, exp_ret);
        return;
      end
      if (i == q.size() - 1 && legal)
        exp_ret = exp_ret + 32'd1;
    end
  endtask

  logic [5:0] legal_ops [9];
  logic [5:0] legal_fns [9];

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    exp_ret = 32'd0;
    legal_ops = '{6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
    legal_fns = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    rst            = 1'b1;
    bus.opcode     = 6'h00;
    bus.funct      = 6'h00;
    bus.zero       = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;

    // Reset held two cycles, then idle fetch with no instruction ready
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checkOutput("reset_state", 32'(state), 32'd0);
      checkOutput("reset_ctl", 32'(ctl_obs), 32'd0);
      checkOutput("reset_retired", retired, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("idle_state", 32'(state), 32'd0);
      checkOutput("idle_ctl", 32'(ctl_obs), 32'd0);
      checkOutput("idle_retired", retired, 32'd0);
      @(negedge clk);
    end

    $display("[TB] directed instructions");
    applyStimulus(6'h00, 6'h21, 1'b0, 0, 0, -1);   // addu
    applyStimulus(6'h23, 6'h00, 1'b0, 0, 3, -1);   // lw, 3 stall cycles
    applyStimulus(6'h04, 6'h00, 1'b1, 0, 0, -1);   // beq taken
    applyStimulus(6'h04, 6'h00, 1'b0, 0, 0, -1);   // beq not taken
    applyStimulus(6'h03, 6'h00, 1'b0, 0, 0, -1);   // jal
    applyStimulus(6'h3F, 6'h15, 1'b0, 0, 0, -1);   // undecodable
    applyStimulus(6'h00, 6'h20, 1'b0, 1, 0, -1);   // R-type, unknown funct
    applyStimulus(6'h2B, 6'h00, 1'b0, 0, 2, 3);    // sw, reset in MEM

    $display("[TB] random instructions");
    for (int n = 0; n < 250; n++) begin
      int sel;
      logic [5:0] op;
      logic [5:0] fn;
      int rat;
      sel = int'($urandom_range(0, 9));
      if (sel == 9) begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end else begin
        op = legal_ops[sel];
        fn = legal_fns[sel];
      end
      rat = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 6)) : -1;
      applyStimulus(op, fn, 1'($urandom), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)), rat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
